muldiv_ctrl: RTL and testbench

- Iterative multiply/divide sequencer beside the EX-stage ALU; executes MULT, MULTU, DIV and DIVU over multiple cycles into private HI/LO registers.
- Raises a stall request to the hazard logic while the EX stage needs HI/LO or the unit while a prior operation is in flight.
- Sits in parallel with the ALU. Operands come from the EX pipeline register bus outputs (BusA, BusB).

---
 rtl/muldiv_ctrl.sv | 170 +++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer with private HI/LO and hazard stall request.
// Optional MULDIV_EARLY_OUT_EN: multiply finishes once the remaining multiplier bits are zero.
module muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_src_a,
    input  logic [WIDTH-1:0] i_src_b,
    input  logic             i_wr_hi,
    input  logic             i_wr_lo,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_req,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_stall_req,
    output logic             o_div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    logic [1:0]         r_state;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplr;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_dvsr;
    logic [WIDTH-1:0]   r_a_raw;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_dz;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_dz_flag;

    logic               w_a_neg, w_b_neg, w_b_zero;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag;
    logic [2*WIDTH-1:0] w_prod_nxt, w_prod_fix;
    logic [WIDTH:0]     w_rem_sh, w_rem_sub;
    logic [WIDTH-1:0]   w_quo_fix, w_rem_fix;
    logic               w_last, w_mul_last, w_mul_skip;

    // Signed ops iterate on magnitudes; signs are reapplied in FIX.
    assign w_a_neg  = i_op[0] & i_src_a[WIDTH-1];
    assign w_b_neg  = i_op[0] & i_src_b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -i_src_a : i_src_a;
    assign w_b_mag  = w_b_neg ? -i_src_b : i_src_b;
    assign w_b_zero = (i_src_b == '0);

    assign w_prod_nxt = r_prod + (r_mplr[0] ? r_mcand : '0);
    assign w_rem_sh   = {r_rem, r_quo[WIDTH-1]};
    assign w_rem_sub  = w_rem_sh - {1'b0, r_dvsr};
    assign w_last     = (r_cnt == CW'(WIDTH-1));

`ifdef MULDIV_EARLY_OUT_EN
    assign w_mul_last = w_last | (r_mplr[WIDTH-1:1] == '0);
    assign w_mul_skip = w_b_zero;
`else
    assign w_mul_last = w_last;
    assign w_mul_skip = 1'b0;
`endif

    assign w_prod_fix = r_neg_q ? -r_prod : r_prod;
    assign w_quo_fix  = r_neg_q ? -r_quo : r_quo;
    assign w_rem_fix  = r_neg_r ? -r_rem : r_rem;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_mcand   <= '0;
            r_mplr    <= '0;
            r_prod    <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_dvsr    <= '0;
            r_a_raw   <= '0;
            r_is_div  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_dz      <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
            r_dz_flag <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_wr_hi) r_hi <= i_wr_data;
                    if (i_wr_lo) r_lo <= i_wr_data;
                    if (i_start) begin
                        r_cnt     <= '0;
                        r_mcand   <= {{WIDTH{1'b0}}, w_a_mag};
                        r_mplr    <= w_b_mag;
                        r_prod    <= '0;
                        r_rem     <= '0;
                        r_quo     <= w_a_mag;
                        r_dvsr    <= w_b_mag;
                        r_a_raw   <= i_src_a;
                        r_is_div  <= i_op[1];
                        r_neg_q   <= w_a_neg ^ w_b_neg;
                        r_neg_r   <= w_a_neg;
                        r_dz      <= i_op[1] & w_b_zero;
                        r_dz_flag <= 1'b0;
                        if (i_op[1])
                            r_state <= w_b_zero ? S_FIX : S_DIV;
                        else
                            r_state <= w_mul_skip ? S_FIX : S_MUL;
                    end
                end
                S_MUL: begin
                    r_prod  <= w_prod_nxt;
                    r_mcand <= r_mcand << 1;
                    r_mplr  <= r_mplr >> 1;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_mul_last) r_state <= S_FIX;
                end
                S_DIV: begin
                    // Restoring step: keep the difference only when it did not borrow.
                    if (!w_rem_sub[WIDTH]) begin
                        r_rem <= w_rem_sub[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b1};
                    end else begin
                        r_rem <= w_rem_sh[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) r_state <= S_FIX;
                end
                default: begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                    if (r_dz) begin
                        r_lo      <= '1;
                        r_hi      <= r_a_raw;
                        r_dz_flag <= 1'b1;
                    end else if (r_is_div) begin
                        r_lo <= w_quo_fix;
                        r_hi <= w_rem_fix;
                    end else begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end
                end
            endcase
        end
    end

    assign o_hi          = r_hi;
    assign o_lo          = r_lo;
    assign o_busy        = (r_state != S_IDLE);
    assign o_done        = r_done;
    assign o_div_by_zero = r_dz_flag;
    assign o_stall_req   = o_busy & (i_start | i_rd_req | i_wr_hi | i_wr_lo);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: random and directed ops checked against an arithmetic model.
module tb_muldiv_ctrl;

    logic        i_clk, i_rst_n, i_start, i_wr_hi, i_wr_lo, i_rd_req;
    logic [1:0]  i_op;
    logic [31:0] i_src_a, i_src_b, i_wr_data;
    logic [31:0] o_hi, o_lo;
    logic        o_busy, o_done, o_stall_req, o_div_by_zero;

    muldiv_ctrl #(.WIDTH(32)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_op(i_op),
        .i_src_a(i_src_a), .i_src_b(i_src_b), .i_wr_hi(i_wr_hi), .i_wr_lo(i_wr_lo),
        .i_wr_data(i_wr_data), .i_rd_req(i_rd_req), .o_hi(o_hi), .o_lo(o_lo),
        .o_busy(o_busy), .o_done(o_done), .o_stall_req(o_stall_req),
        .o_div_by_zero(o_div_by_zero)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          n;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   busy_run = 0;

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the architectural operation.
    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [63:0] p;
        longint      sa, sbv, q, r;
        int          msb;
        e.dz = 1'b0;
        e.lat = 33;
        if (op[1] && b == 32'd0) begin
            e.lo = 32'hFFFF_FFFF; e.hi = a; e.dz = 1'b1; e.lat = 1;
        end else if (op == 2'b00) begin
            p = 64'(a) * 64'(b);
            e.hi = p[63:32]; e.lo = p[31:0];
        end else if (op == 2'b01) begin
            sa = longint'($signed(a)); sbv = longint'($signed(b));
            p = 64'(sa * sbv);
            e.hi = p[63:32]; e.lo = p[31:0];
        end else if (op == 2'b10) begin
            e.lo = a / b; e.hi = a % b;
        end else begin
            sa = longint'($signed(a)); sbv = longint'($signed(b));
            q = sa / sbv; r = sa % sbv;
            e.lo = q[31:0]; e.hi = r[31:0];
        end
`ifdef MULDIV_EARLY_OUT_EN
        if (!op[1]) begin
            msb = -1;
            for (int i = 0; i < 32; i++) if (b[i]) msb = i;
            e.lat = msb + 2;
        end
`else
        msb = 0;
`endif
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge i_clk) begin
        if (o_busy) busy_run <= busy_run + 1;
        else begin
            if (o_done) begin
                if (sb.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL unexpected_done: done with empty scoreboard at cycle %0d", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("done_hi", 64'(o_hi), 64'(e.hi));
                    check("done_lo", 64'(o_lo), 64'(e.lo));
                    check("done_dz", 64'(o_div_by_zero), 64'(e.dz));
                    check("done_latency", 64'(cyc - e.n), 64'(e.lat));
                    check("busy_cycles", 64'(busy_run), 64'(e.lat));
                end
            end
            busy_run <= 0;
        end
    end

    task automatic wait_idle();
        int k = 0;
        @(negedge i_clk);
        while (o_busy && k < 200) begin
            @(negedge i_clk);
            k++;
        end
        if (o_busy) begin
            n_chk++; n_err++;
            $display("FAIL idle_timeout: busy still %0d after %0d cycles", o_busy, k);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic wlo, input logic [31:0] wdata);
        exp_t e;
        wait_idle();
        e = model(op, a, b);
        e.n = cyc + 1;
        sb.push_back(e);
        i_start = 1'b1; i_op = op; i_src_a = a; i_src_b = b;
        i_wr_lo = wlo; i_wr_data = wdata;
        @(posedge i_clk); #1;
        i_start = 1'b0; i_wr_lo = 1'b0;
        if (wlo && e.lat > 1) check("mtlo_with_start", 64'(o_lo), 64'(wdata));
    endtask

    initial begin
        exp_t        e;
        int          n, seen;
        logic [1:0]  op;
        logic [31:0] a, b;

        i_rst_n = 1'b0; i_start = 1'b0; i_op = 2'b00; i_src_a = '0; i_src_b = '0;
        i_wr_hi = 1'b0; i_wr_lo = 1'b0; i_wr_data = '0; i_rd_req = 1'b0;
        repeat (2) @(negedge i_clk);
        check("rst_hi", 64'(o_hi), 64'd0);
        check("rst_lo", 64'(o_lo), 64'd0);
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_done", 64'(o_done), 64'd0);
        check("rst_dz", 64'(o_div_by_zero), 64'd0);
        i_rst_n = 1'b1;

        // Directed arithmetic corners.
        issue(2'b01, 32'hFFFF_FFFD, 32'd7, 1'b0, '0);
        issue(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, '0);
        issue(2'b10, 32'd100, 32'd7, 1'b0, '0);
        issue(2'b10, 32'h0000_1234, 32'd0, 1'b0, '0);
        wait_idle();
        check("dz_sticky", 64'(o_div_by_zero), 64'd1);
        issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, '0);
        check("dz_cleared_by_start", 64'(o_div_by_zero), 64'd0);
        issue(2'b01, 32'h8000_0000, 32'h8000_0000, 1'b0, '0);
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, '0);
        issue(2'b11, 32'd7, 32'hFFFF_FFFE, 1'b0, '0);

        // Hazard: read request mid-op stalls through FIX, ignored start while busy.
        a = $urandom; b = $urandom | 32'h8000_0000;
        e = model(2'b00, a, b);
        issue(2'b00, a, b, 1'b0, '0);
        n = cyc;
        repeat (4) @(negedge i_clk);
        i_rd_req = 1'b1;
        while (cyc < n + 33) begin
            #1 check("stall_in_flight", 64'(o_stall_req), 64'd1);
            if (cyc == n + 10) begin
                i_start = 1'b1; i_op = 2'b10; i_src_a = 32'h55; i_src_b = 32'd0;
            end else i_start = 1'b0;
            @(negedge i_clk);
        end
        #1 check("stall_released", 64'(o_stall_req), 64'd0);
        check("hazard_hi", 64'(o_hi), 64'(e.hi));
        check("hazard_lo", 64'(o_lo), 64'(e.lo));
        i_rd_req = 1'b0;

        // MTHI/MTLO in IDLE, then MTLO in the same cycle as a start.
        wait_idle();
        i_wr_hi = 1'b1; i_wr_data = 32'hA5A5_A5A5;
        #1 check("mthi_no_stall", 64'(o_stall_req), 64'd0);
        @(posedge i_clk); #1;
        i_wr_hi = 1'b0;
        check("mthi_value", 64'(o_hi), 64'hA5A5_A5A5);
        i_wr_lo = 1'b1; i_wr_data = 32'h5A5A_0F0F;
        @(posedge i_clk); #1;
        i_wr_lo = 1'b0;
        check("mtlo_value", 64'(o_lo), 64'h5A5A_0F0F);
        issue(2'b10, 32'd1000, 32'd33, 1'b1, 32'hDEAD_BEEF);

`ifdef MULDIV_EARLY_OUT_EN
        issue(2'b00, 32'h1357_9BDF, 32'd1, 1'b0, '0);
        issue(2'b00, 32'h1357_9BDF, 32'd0, 1'b0, '0);
`endif

        // Randomized mix, biased toward small and zero divisors.
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                default: b = $urandom;
            endcase
            issue(op, a, b, 1'b0, '0);
        end

        // Reset mid-DIV aborts the op and leaves no later done.
        issue(2'b10, 32'hFFFF_0000, 32'd3, 1'b0, '0);
        repeat (10) @(negedge i_clk);
        i_rst_n = 1'b0;
        sb.delete();
        repeat (2) @(negedge i_clk);
        check("midrst_hi", 64'(o_hi), 64'd0);
        check("midrst_lo", 64'(o_lo), 64'd0);
        check("midrst_busy", 64'(o_busy), 64'd0);
        check("midrst_done", 64'(o_done), 64'd0);
        i_rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge i_clk);
            if (o_done || o_busy) seen++;
        end
        check("no_done_after_rst", 64'(seen), 64'd0);

        issue(2'b01, $urandom, $urandom, 1'b0, '0);
        wait_idle();
        repeat (3) @(negedge i_clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
